// File: rtl/io_pkg.sv
// io_pkg: shared types and constants for the BCD seven-segment output stage.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package io_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Largest value six decimal digits can show.
    localparam int IO_MAX_VAL = 999999;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: one BCD digit to active-low seven-segment pattern.
// Non-decimal codes never occur after double-dabble; they decode to blank.
module seg7_decode
    import io_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Table lookup; the default arm covers codes 10..15.
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = SEG_DIGIT[0];
            4'd1: seg = SEG_DIGIT[1];
            4'd2: seg = SEG_DIGIT[2];
            4'd3: seg = SEG_DIGIT[3];
            4'd4: seg = SEG_DIGIT[4];
            4'd5: seg = SEG_DIGIT[5];
            4'd6: seg = SEG_DIGIT[6];
            4'd7: seg = SEG_DIGIT[7];
            4'd8: seg = SEG_DIGIT[8];
            4'd9: seg = SEG_DIGIT[9];
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/io_bcd_hex_driver.sv
// io_bcd_hex_driver: shows a 32-bit output-port value in decimal on six
// seven-segment displays. Binary-to-BCD is a serial double-dabble, one bit
// per clock; a one-deep pending buffer holds the latest write made while a
// conversion is running.
// Optional: define IO_BCD_LEADING_ZERO_BLANK_EN to blank leading zeros.
module io_bcd_hex_driver
    import io_pkg::*;
#(
    parameter int DATA_W     = 20,
    parameter int NUM_DIGITS = 6,
    parameter int MAX_VAL    = IO_MAX_VAL
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        ovf,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    state_t                          state, state_nxt;
    logic [CNT_W-1:0]                cnt;
    logic [DATA_W-1:0]               bin;
    logic [NUM_DIGITS-1:0][3:0]      bcd, bcd_adj;
    logic                            ovf_next;
    logic                            pend_vld;
    logic [31:0]                     pend_data;
    logic [NUM_DIGITS-1:0][6:0]      seg_dig, seg_show, hex_q;
    logic                            start;
    logic [31:0]                     start_val;
    logic                            ovf_calc;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state: SHIFT runs exactly DATA_W edges; UPDATE chains straight
    // into the next conversion when a write is waiting or arriving.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (wr_en) state_nxt = SHIFT;
            SHIFT:   if (cnt == CNT_W'(1)) state_nxt = UPDATE;
            UPDATE:  state_nxt = (wr_en || pend_vld) ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A fresh write in the UPDATE cycle is newer than the buffered one.
    assign start     = (state != SHIFT) && (state_nxt == SHIFT);
    assign start_val = (state == UPDATE && !wr_en) ? pend_data : wr_data;
    assign ovf_calc  = ((start_val >> DATA_W) != 32'd0) ||
                       (32'(start_val[DATA_W-1:0]) > 32'(MAX_VAL));
    assign busy      = (state != IDLE);

    // Per-digit add-3 correction and segment decode.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        assign bcd_adj[i] = (bcd[i] >= 4'd5) ? bcd[i] + 4'd3 : bcd[i];
        seg7_decode u_dec (.bcd(bcd[i]), .seg(seg_dig[i]));
    end

    // Optional leading-zero blanking; hex0 always shows its digit.
    always_comb begin : blank_p
`ifdef IO_BCD_LEADING_ZERO_BLANK_EN
        logic lead;
        lead     = 1'b1;
`endif
        seg_show = seg_dig;
`ifdef IO_BCD_LEADING_ZERO_BLANK_EN
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            lead = lead && (bcd[i] == 4'd0);
            if (lead) seg_show[i] = SEG_BLANK;
        end
`endif
    end

    // Conversion datapath, pending buffer and registered display outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            bin       <= '0;
            bcd       <= '0;
            ovf_next  <= 1'b0;
            pend_vld  <= 1'b0;
            pend_data <= '0;
            hex_q     <= {NUM_DIGITS{SEG_DIGIT[0]}};
            ovf       <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                bin      <= start_val[DATA_W-1:0];
                bcd      <= '0;
                cnt      <= CNT_W'(DATA_W);
                ovf_next <= ovf_calc;
            end else if (state == SHIFT) begin
                {bcd, bin} <= {bcd_adj, bin} << 1;
                cnt        <= cnt - CNT_W'(1);
            end
            if (state == SHIFT && wr_en) begin
                pend_vld  <= 1'b1;
                pend_data <= wr_data;
            end
            if (state == UPDATE) begin
                hex_q    <= ovf_next ? {NUM_DIGITS{SEG_DASH}} : seg_show;
                ovf      <= ovf_next;
                done     <= 1'b1;
                pend_vld <= 1'b0;
            end
        end
    end

    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
    assign hex4 = hex_q[4];
    assign hex5 = hex_q[5];

endmodule

// File: tb/tb_io_bcd_hex_driver.sv
// Randomized bench for io_bcd_hex_driver with a cycle-level behavioural
// model (decimal arithmetic, countdown to the display update, latest-wins
// pending slot) plus hand-computed literal checks.
module tb_io_bcd_hex_driver;

    localparam int LAT = 21;
`ifdef IO_BCD_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = 7'h7F;
`else
    localparam logic [6:0] LZ = 7'h40;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        busy, done, ovf;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

    io_bcd_hex_driver dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .busy(busy), .done(done), .ovf(ovf),
        .hex0(hex0), .hex1(hex1), .hex2(hex2),
        .hex3(hex3), .hex4(hex4), .hex5(hex5)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [6:0]  seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [6:0]  exp_hex [6];
    logic        exp_ovf, exp_done;
    int          m_left;        // edges until the display update, 0 = idle
    bit          m_pend_v;
    logic [31:0] m_pend, m_cur;

    task automatic show(input logic [31:0] v);
        int p;
        p = 1;
        if (v > 32'd999999) begin
            for (int i = 0; i < 6; i++) exp_hex[i] = 7'h3F;
            exp_ovf = 1'b1;
        end else begin
            exp_ovf = 1'b0;
            for (int i = 0; i < 6; i++) begin
                exp_hex[i] = seg_tbl[(v / p) % 10];
`ifdef IO_BCD_LEADING_ZERO_BLANK_EN
                if (i > 0 && v < p) exp_hex[i] = 7'h7F;
`endif
                p = p * 10;
            end
        end
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_left = 0; m_pend_v = 0; exp_ovf = 0; exp_done = 0;
            for (int i = 0; i < 6; i++) exp_hex[i] = 7'h40;
        end else begin
            exp_done = 0;
            if (m_left == 0) begin
                if (wr_en) begin m_cur = wr_data; m_left = LAT; end
            end else if (m_left == 1) begin
                show(m_cur);
                exp_done = 1;
                if (wr_en)         begin m_cur = wr_data; m_left = LAT; end
                else if (m_pend_v) begin m_cur = m_pend;  m_left = LAT; end
                else m_left = 0;
                m_pend_v = 0;
            end else begin
                if (wr_en) begin m_pend = wr_data; m_pend_v = 1; end
                m_left--;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clock) begin
        chk("busy", 64'(busy), 64'(m_left != 0));
        chk("done", 64'(done), 64'(exp_done));
        chk("ovf",  64'(ovf),  64'(exp_ovf));
        chk("hex",  64'({hex5, hex4, hex3, hex2, hex1, hex0}),
            64'({exp_hex[5], exp_hex[4], exp_hex[3], exp_hex[2], exp_hex[1], exp_hex[0]}));
    end

    // ---------------- stimulus helpers ----------------
    task automatic write(input logic [31:0] v);
        @(negedge clock); wr_en = 1'b1; wr_data = v;
        @(negedge clock); wr_en = 1'b0;
    endtask

    task automatic wait_done(input string name, output int cyc);
        cyc = 0;
        while (!done && cyc < 60) begin @(negedge clock); cyc++; end
        chk(name, 64'(done), 64'd1);
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 3))
            0: return 32'($urandom_range(0, 99));
            1: return 32'($urandom_range(0, 999999));
            2: return 32'($urandom_range(1000000, 1048575));
            default: return $urandom;
        endcase
    endfunction

    logic [41:0] hx;
    assign hx = {hex5, hex4, hex3, hex2, hex1, hex0};

    initial begin
        int c, nb, nd;
        // 1: reset state
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_hex",  64'(hx), 64'({6{7'h40}}));
        chk("rst_flags", 64'({busy, done, ovf}), 64'd0);

        // 2: value 36, busy length and single done
        write(32'd36);
        nb = 0; nd = 0;
        repeat (40) begin
            if (busy) nb++;
            if (done) nd++;
            @(negedge clock);
        end
        chk("busy_len", 64'(nb), 64'd21);
        chk("done_cnt", 64'(nd), 64'd1);
        chk("hex_36", 64'(hx), 64'({LZ, LZ, LZ, LZ, 7'h30, 7'h02}));
        chk("ovf_36", 64'(ovf), 64'd0);

        // 3: max value then overflow
        write(32'd999999);
        wait_done("to_999999", c);
        chk("hex_999999", 64'(hx), 64'({6{7'h10}}));
        write(32'd1000000);
        wait_done("to_1000000", c);
        chk("hex_ovf", 64'(hx), 64'({6{7'h3F}}));
        chk("ovf_flag", 64'(ovf), 64'd1);
        write(32'h0010_0005);   // upper bits set
        wait_done("to_hibits", c);
        chk("ovf_hibits", 64'(ovf), 64'd1);

        // 4: pending buffer, latest write wins
        write(32'd123456);
        repeat (3) @(negedge clock);
        write(32'd7);
        write(32'd42);
        wait_done("to_123456", c);
        chk("hex_123456", 64'(hx), 64'({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}));
        @(negedge clock);
        wait_done("to_42", c);
        chk("gap_42", 64'(c), 64'd20);
        chk("hex_42", 64'(hx), 64'({LZ, LZ, LZ, LZ, 7'h19, 7'h24}));

        // 5: reset mid-conversion with a pending write
        write(32'd555555);
        repeat (4) @(negedge clock);
        write(32'd31);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_hex",  64'(hx), 64'({6{7'h40}}));
        chk("mid_rst_busy", 64'({busy, done, ovf}), 64'd0);
        @(negedge clock); @(negedge clock);
        reset = 1'b0;
        nd = 0;
        repeat (50) begin @(negedge clock); if (done || busy) nd++; end
        chk("post_rst_quiet", 64'(nd), 64'd0);

`ifdef IO_BCD_LEADING_ZERO_BLANK_EN
        // 6: leading zero blanking
        write(32'd305);
        wait_done("to_305", c);
        chk("hex_305", 64'(hx), 64'({7'h7F, 7'h7F, 7'h7F, 7'h30, 7'h40, 7'h12}));
        write(32'd0);
        wait_done("to_0", c);
        chk("hex_0", 64'(hx), 64'({{5{7'h7F}}, 7'h40}));
`endif

        // Random traffic: alternating dense and sparse write phases.
        for (int n = 0; n < 4000; n++) begin
            @(negedge clock);
            if (((n / 500) % 2) == 1) wr_en = ($urandom_range(0, 3) == 0);
            else                      wr_en = ($urandom_range(0, 39) == 0);
            wr_data = rand_val();
        end
        @(negedge clock);
        wr_en = 1'b0;
        repeat (60) @(negedge clock);
        chk("end_idle", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/io_bcd_hex_driver.md
Name: io_bcd_hex_driver

Overview:
- Output-side I/O stage of the single-cycle computer: consumes 32-bit values written to an output port and shows them as decimal on the six DE1-SoC seven-segment displays (hex0..hex5).
- Converts binary to BCD with a sequential double-dabble engine, one bit per cycle.
- Includes a one-deep pending buffer so back-to-back port writes are never lost.

Parameters:
- DATA_W, 20: number of low bits of wr_data converted (20 covers 999999).
- NUM_DIGITS, 6: number of displays and BCD digits; fixed at 6 for port count.
- MAX_VAL, 999999: largest displayable value; must equal 10^NUM_DIGITS - 1.

Ports:
- clock, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- wr_en, input, 1: single-cycle write strobe from the output-port decode.
- wr_data, input, 32: port value; only bits [DATA_W-1:0] are converted.
- busy, output, 1: conversion in progress.
- done, output, 1: one-cycle pulse when the hex outputs update.
- ovf, output, 1: last displayed value exceeded MAX_VAL, or had nonzero bits above DATA_W.
- hex0..hex5, output, 7 each: active-low segments {g,f,e,d,c,b,a}. hex0 is the least-significant digit.

Behaviour:
- Reset values (asynchronous, active-high):
  - state IDLE; busy=0, done=0, ovf=0; pending buffer empty.
  - hex0..hex5 = 7'h40, so all displays read "0".
- FSM states: IDLE, SHIFT, UPDATE.
- IDLE:
  - On a clock edge with wr_en=1, capture wr_data.
  - Compute ovf_next: 1 if wr_data[31:DATA_W] != 0 or wr_data[DATA_W-1:0] > MAX_VAL.
  - Clear the 24-bit BCD register, load the shift register, set the shift counter to DATA_W, go to SHIFT. busy=1 from this edge.
- SHIFT:
  - Each edge: add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by 1 and decrement the counter.
  - After exactly DATA_W shift edges, go to UPDATE.
- UPDATE:
  - On the next edge, register the decoded digits into hex0..hex5, or the overflow pattern 7'h3F ("-") on all six when ovf_next=1.
  - Register ovf and pulse done=1 for one cycle.
  - If the pending buffer is full, capture its value in the same edge (as in IDLE), empty the buffer, go to SHIFT with busy held at 1.
  - Otherwise go to IDLE with busy=0.
- Latency: capture edge at T; hex, done and ovf update on edge T+DATA_W+1 (21 cycles at default). Hex outputs are stable and glitch-free between updates.
- Pending buffer:
  - wr_en while state != IDLE stores wr_data in the buffer.
  - A later write overwrites it; latest wins, intermediate values are dropped by design.
  - wr_en in the UPDATE cycle with the buffer full: the new wr_data wins and is started at that edge.
- Mid-operation reset: conversion and pending buffer discarded, outputs return to reset values.
- Timing: no combinational path from wr_data to any output.

Optional Feature:
- Macro: IO_BCD_LEADING_ZERO_BLANK_EN.
- Defined: displays above the most-significant nonzero digit are blanked (7'h7F); hex0 is never blanked, so value 0 shows a single "0". Overflow pattern is unaffected.
- Undefined: all six digits are always shown, leading zeros included.

Decomposition:
- Package io_pkg:
  - FSM state enum.
  - Segment constants: SEG_DIGIT[0:9], SEG_BLANK=7'h7F, SEG_DASH=7'h3F.
  - Default MAX_VAL.
- Sub-module seg7_decode: combinational 4-bit BCD to 7-bit active-low decode, instantiated NUM_DIGITS times.

Test Plan:
1. Reset held, then released: hex0..hex5 = 7'h40; busy=0, done=0, ovf=0.
2. wr_en with wr_data=36 (12+24), then idle: busy high for 21 cycles; done pulses on the 21st edge; hex1=7'h30 ("3"), hex0=7'h02 ("6"), others 7'h40; ovf=0.
3. wr_data=999999: hex5..hex0 all 7'h10 ("9"). Then wr_data=1000000: all 7'h3F, ovf=1.
4. wr_data=123456, then wr_en=7 and wr_en=42 during SHIFT:
   - display 123456 with done;
   - conversion of 42 starts immediately; 7 is never displayed;
   - second done gives hex1=7'h19, hex0=7'h24.
5. Reset asserted midway through converting 555555: outputs return to 7'h40 asynchronously; no done pulse; pending write discarded.
6. With IO_BCD_LEADING_ZERO_BLANK_EN defined:
   - wr_data=305 gives hex2=7'h30, hex1=7'h40, hex0=7'h12, hex5..hex3=7'h7F;
   - wr_data=0 gives hex0=7'h40 with the rest blank.
